// File: rtl/spi_gcd_receiver.sv
// spi_gcd_receiver: oversampling SPI slave that frames MSB-first bytes into a FWFT FIFO; `define SPI_ECHO_EN to echo the previous byte on miso
module spi_gcd_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_BITS  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  spi_clock,
    input  logic                  mosi,
    input  logic                  slave_select,
    output logic                  miso,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_BITS:0]    count,
    output logic                  byte_valid,
    output logic                  overflow,
    output logic                  frame_error,
    input  logic                  clear_flags
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [ADDR_BITS:0] CNT_DEPTH = (ADDR_BITS+1)'(FIFO_DEPTH);
    localparam logic [ADDR_BITS:0] FIFO_ONE = (ADDR_BITS+1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [2:0]            sclk_q;
    logic [1:0]            mosi_q;
    logic [1:0]            ss_q;
    state_t                state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  byte_valid_q;
    logic                  overflow_q;
    logic                  frame_error_q;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_q;
    logic [ADDR_BITS-1:0]  rd_ptr_q;
    logic [ADDR_BITS:0]    count_q;
    logic [ADDR_BITS:0]    count_d;
    logic                  sclk_rise;
    logic                  ss_s;
    logic                  mosi_s;
    logic                  do_write;
    logic                  do_pop;
    logic                  ovf_set;
    logic                  ferr_set;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign ss_s      = ss_q[1];
    assign mosi_s    = mosi_q[1];

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_DEPTH);
    assign count       = count_q;
    assign rd_data     = empty ? '0 : mem_q[rd_ptr_q];
    assign byte_valid  = byte_valid_q;
    assign overflow    = overflow_q;
    assign frame_error = frame_error_q;

    assign do_write = (state_q == COMMIT) & (~full | rd_en);
    assign do_pop   = rd_en & ~empty;
    assign ovf_set  = (state_q == COMMIT) & full & ~rd_en;
    assign ferr_set = (state_q == SHIFT) & ss_s & (bit_cnt_q != '0) & (bit_cnt_q != CNT_FULL);

    // Two-flop synchronizers; sclk_q[2] is the delayed copy used for edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_q <= '0;
            mosi_q <= '0;
            ss_q   <= '1;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clock};
            mosi_q <= {mosi_q[0], mosi};
            ss_q   <= {ss_q[0], slave_select};
        end
    end

    // Frame FSM: shift bits on rising spi_clock, hand the byte to the FIFO for one COMMIT cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            byte_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            byte_valid_q  <= 1'b0;
            overflow_q    <= ovf_set | (overflow_q & ~clear_flags);
            frame_error_q <= ferr_set | (frame_error_q & ~clear_flags);
            case (state_q)
                IDLE: begin
                    if (!ss_s) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_cnt_q == CNT_FULL) begin
                        state_q      <= COMMIT;
                        byte_valid_q <= 1'b1;
                    end else if (ss_s) begin
                        state_q   <= IDLE;
                        bit_cnt_q <= '0;
                    end else if (sclk_rise) begin
                        shift_q   <= {shift_q[DATA_WIDTH-2:0], mosi_s};
                        bit_cnt_q <= bit_cnt_q + CNT_ONE;
                    end
                end
                COMMIT: begin
                    bit_cnt_q <= '0;
                    state_q   <= ss_s ? IDLE : SHIFT;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign count_d = (do_write && !do_pop) ? count_q + FIFO_ONE :
                     (!do_write && do_pop) ? count_q - FIFO_ONE : count_q;

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= do_write ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_q <= do_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            count_q  <= count_d;
        end
    end

    // FIFO storage; rd_data is masked while empty so no array reset is needed
    always_ff @(posedge clock) begin
        if (do_write) mem_q[wr_ptr_q] <= shift_q;
    end

`ifdef SPI_ECHO_EN
    logic                  sclk_fall;
    logic [DATA_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] tx_q;

    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign miso      = ~slave_select & tx_q[DATA_WIDTH-1];

    // Echo register; the falling edge right after COMMIT (counter 0) is skipped so the reloaded byte keeps its MSB
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_q <= '0;
            tx_q   <= '0;
        end else if (state_q == COMMIT) begin
            last_q <= shift_q;
            tx_q   <= shift_q;
        end else if (state_q == IDLE && !ss_s) begin
            tx_q <= last_q;
        end else if (state_q == SHIFT && sclk_fall && bit_cnt_q != '0) begin
            tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
        end
    end
`else
    assign miso = 1'b0;
`endif
endmodule

// File: tb/tb_spi_gcd_receiver.sv
// tb_spi_gcd_receiver: directed self-checking bench for spi_gcd_receiver
module tb_spi_gcd_receiver;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       spi_clock = 1'b0;
    logic       mosi = 1'b0;
    logic       slave_select = 1'b1;
    logic       miso;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       byte_valid;
    logic       overflow;
    logic       frame_error;
    logic       clear_flags = 1'b0;

    int         checks = 0;
    int         errors = 0;
    int         bv_cnt = 0;
    logic [7:0] echo_q = 8'h00;

    spi_gcd_receiver dut (
        .clock(clock), .reset(reset), .spi_clock(spi_clock), .mosi(mosi),
        .slave_select(slave_select), .miso(miso), .rd_en(rd_en), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .byte_valid(byte_valid),
        .overflow(overflow), .frame_error(frame_error), .clear_flags(clear_flags)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (byte_valid === 1'b1) bv_cnt++;

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            repeat (8) @(negedge clock);
            echo_q = {echo_q[6:0], miso};
            spi_clock = 1'b1;
            repeat (8) @(negedge clock);
            spi_clock = 1'b0;
        end
    endtask

    task automatic frame_start;
        slave_select = 1'b0;
        repeat (8) @(negedge clock);
    endtask

    task automatic frame_end;
        repeat (8) @(negedge clock);
        slave_select = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b);
        frame_start();
        spi_bits(b, 8);
        frame_end();
    endtask

    task automatic pop(output logic [7:0] d);
        d = rd_data;
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_fifo count=%0d empty=%b full=%b exp 0/1/0", count, empty, full);
        end
        checks++;
        if ({byte_valid, overflow, frame_error, miso} !== 4'b0000 || rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_out bv/ovf/ferr/miso=%b%b%b%b rd_data=%h exp 0000/00",
                     byte_valid, overflow, frame_error, miso, rd_data);
        end
    endtask

    task automatic test_single;
        int         bv0;
        logic [7:0] d;
        bv0 = bv_cnt;
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL pop_empty count=%0d empty=%b exp 0/1", count, empty);
        end
        frame_start();
        spi_bits(8'h2A, 7);
        mosi = 1'b0;
        repeat (8) @(negedge clock);
        spi_clock = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (count !== 5'd0 || byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early count=%0d bv=%b exp 0/0", count, byte_valid);
        end
        @(negedge clock);
        checks++;
        if (byte_valid !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL latency_commit bv=%b count=%0d exp 1/0", byte_valid, count);
        end
        @(negedge clock);
        checks++;
        if (count !== 5'd1 || empty !== 1'b0 || rd_data !== 8'h2A || byte_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_write count=%0d empty=%b rd_data=%h bv=%b exp 1/0/2a/0",
                     count, empty, rd_data, byte_valid);
        end
        repeat (3) @(negedge clock);
        spi_clock = 1'b0;
        frame_end();
        checks++;
        if (bv_cnt - bv0 !== 1) begin
            errors++;
            $display("FAIL single_bv pulses=%0d exp 1", bv_cnt - bv0);
        end
        pop(d);
        checks++;
        if (d !== 8'h2A || empty !== 1'b1 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_pop data=%h empty=%b count=%0d exp 2a/1/0", d, empty, count);
        end
    endtask

    task automatic test_multi;
        int         bv0;
        logic [7:0] d;
        logic [7:0] exp_b [3] = '{8'h06, 8'h0F, 8'h01};
        bv0 = bv_cnt;
        frame_start();
        for (int i = 0; i < 3; i++) spi_bits(exp_b[i], 8);
        frame_end();
        checks++;
        if (bv_cnt - bv0 !== 3 || count !== 5'd3 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL multi_status pulses=%0d count=%0d ferr=%b exp 3/3/0",
                     bv_cnt - bv0, count, frame_error);
        end
        for (int i = 0; i < 3; i++) begin
            pop(d);
            checks++;
            if (d !== exp_b[i]) begin
                errors++;
                $display("FAIL multi_pop%0d got %h exp %h", i, d, exp_b[i]);
            end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        for (int i = 0; i < 17; i++) send_frame(8'(i));
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_status count=%0d full=%b ovf=%b exp 16/1/1", count, full, overflow);
        end
        for (int i = 0; i < 16; i++) begin
            pop(d);
            checks++;
            if (d !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_pop%0d got %h exp %h", i, d, 8'(i));
            end
        end
        checks++;
        if (empty !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained empty=%b ovf=%b exp 1/1", empty, overflow);
        end
        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear ovf=%b exp 0", overflow);
        end
    endtask

    task automatic test_frame_error;
        int         bv0;
        logic [7:0] d;
        bv0 = bv_cnt;
        frame_start();
        spi_bits(8'hFF, 5);
        frame_end();
        checks++;
        if (frame_error !== 1'b1 || count !== 5'd0 || bv_cnt != bv0) begin
            errors++;
            $display("FAIL ferr_set ferr=%b count=%0d pulses=%0d exp 1/0/0", frame_error, count, bv_cnt - bv0);
        end
        send_frame(8'hC3);
        checks++;
        if (count !== 5'd1 || rd_data !== 8'hC3) begin
            errors++;
            $display("FAIL ferr_next count=%0d rd_data=%h exp 1/c3", count, rd_data);
        end
        pop(d);
        clear_flags = 1'b1;
        @(negedge clock);
        clear_flags = 1'b0;
        checks++;
        if (frame_error !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL ferr_clear ferr=%b empty=%b exp 0/1", frame_error, empty);
        end
    endtask

    task automatic test_full_pop;
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i));
        frame_start();
        spi_bits(8'h5A, 7);
        mosi = 1'b0;
        repeat (8) @(negedge clock);
        spi_clock = 1'b1;
        for (int k = 0; k < 10 && byte_valid !== 1'b1; k++) @(negedge clock);
        checks++;
        if (byte_valid !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_commit bv=%b full=%b exp 1/1", byte_valid, full);
        end
        rd_en = 1'b1;
        @(negedge clock);
        rd_en = 1'b0;
        repeat (6) @(negedge clock);
        spi_clock = 1'b0;
        frame_end();
        checks++;
        if (overflow !== 1'b0 || count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_status ovf=%b count=%0d full=%b exp 0/16/1", overflow, count, full);
        end
        for (int i = 1; i <= 16; i++) begin
            pop(d);
            e = (i == 16) ? 8'h5A : 8'h80 + 8'(i);
            checks++;
            if (d !== e) begin
                errors++;
                $display("FAIL fullpop_pop%0d got %h exp %h", i, d, e);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        send_frame(8'h77);
        frame_start();
        spi_bits(8'hF0, 4);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || rd_data !== 8'h00 || byte_valid !== 1'b0 || miso !== 1'b0) begin
            errors++;
            $display("FAIL midreset count=%0d empty=%b rd_data=%h bv=%b miso=%b exp 0/1/00/0/0",
                     count, empty, rd_data, byte_valid, miso);
        end
        @(negedge clock);
        reset = 1'b0;
        slave_select = 1'b1;
        repeat (8) @(negedge clock);
        send_frame(8'h81);
        checks++;
        if (count !== 5'd1 || rd_data !== 8'h81 || frame_error !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next count=%0d rd_data=%h ferr=%b exp 1/81/0", count, rd_data, frame_error);
        end
        pop(d);
    endtask

`ifdef SPI_ECHO_EN
    task automatic test_echo;
        logic [7:0] d;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        send_frame(8'h12);
        checks++;
        if (echo_q !== 8'h00) begin
            errors++;
            $display("FAIL echo_first got %h exp 00", echo_q);
        end
        send_frame(8'h34);
        checks++;
        if (echo_q !== 8'h12) begin
            errors++;
            $display("FAIL echo_second got %h exp 12", echo_q);
        end
        pop(d);
        pop(d);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_overflow();
        test_frame_error();
        test_full_pop();
        test_reset_mid();
`ifdef SPI_ECHO_EN
        test_echo();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_gcd_receiver.md
Name: spi_gcd_receiver

Overview:
- SPI slave deserializer downstream of the memory reader's SPI master; consumes its mosi/slave_select/spi_clock stream of GCD result bytes.
- Oversamples the SPI pins in the system clock domain, assembles 8-bit frames and buffers them in a first-word-fall-through FIFO for a display/checker stage.
- Flags overflow and truncated frames.

Parameters:
DATA_WIDTH, 8, bits per SPI frame; MSB first
FIFO_DEPTH, 16, FIFO entries; power of two
ADDR_BITS, 4, log2(FIFO_DEPTH)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
spi_clock  input  1  SPI serial clock; idle low; asynchronous to clock
mosi  input  1  serial data; sampled on rising spi_clock
slave_select  input  1  active-low frame enable
miso  output  1  echo data (see Optional Feature); 0 when feature absent
rd_en  input  1  pop head entry
rd_data  output  DATA_WIDTH  FIFO head; valid while empty=0
empty  output  1  FIFO empty
full  output  1  FIFO full
count  output  ADDR_BITS+1  entries held, 0..FIFO_DEPTH
byte_valid  output  1  one-cycle pulse per completed frame (written or dropped)
overflow  output  1  sticky; byte completed while full with no pop
frame_error  output  1  sticky; slave_select released mid-byte
clear_flags  input  1  synchronous clear of overflow and frame_error

Behaviour:
- Reset (async, any time, including mid-byte): state IDLE, bit counter 0, shift register 0, FIFO pointers 0, count=0, empty=1, full=0, rd_data=0, byte_valid=0, overflow=0, frame_error=0, miso=0. Partial byte is discarded.
- Synchronization:
  - spi_clock, mosi and slave_select each pass through a 2-FF synchronizer.
  - A rising or falling spi_clock edge is detected by comparing the synchronized value with a one-cycle-delayed copy.
  - spi_clock high and low phases are each at least 4 clock periods; this is a requirement on the SPI master.
- FSM states:
  - IDLE: synchronized slave_select=1. Edges on spi_clock and mosi are ignored. slave_select=0 -> SHIFT, bit counter cleared.
  - SHIFT: each rising spi_clock edge shifts synchronized mosi into the LSB and increments the bit counter. When the counter reaches DATA_WIDTH -> COMMIT.
  - SHIFT, slave_select=1 with counter 0 -> IDLE, no flag.
  - SHIFT, slave_select=1 with counter 1..DATA_WIDTH-1 -> IDLE, frame_error<=1, partial byte discarded.
  - COMMIT (exactly 1 cycle):
    - byte_valid=1 and bit counter cleared.
    - If full=0 or rd_en=1: write the byte.
    - Otherwise: drop the byte and set overflow<=1.
    - Next state is SHIFT if slave_select=0, else IDLE.
- Latency: the written byte appears on rd_data with empty=0 on the 4th clock edge after the first edge that samples the 8th spi_clock rising edge at the pin.
- FIFO:
  - First-word-fall-through: rd_data always equals the head entry.
  - rd_en with empty=1 is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and pop: both happen, count unchanged. This holds when full; when empty, no pop occurs and count goes to 1.
  - full = (count==FIFO_DEPTH); empty = (count==0).
- Flags: overflow and frame_error hold until clear_flags or reset. If clear_flags and a new set event occur in the same cycle, set wins.

Optional Feature:
- Macro SPI_ECHO_EN.
- Defined:
  - A transmit shift register holds the last committed byte, 0x00 after reset.
  - It is loaded on entry to SHIFT from IDLE and in each COMMIT.
  - It shifts left on each falling spi_clock edge while in SHIFT.
  - miso = transmit MSB while slave_select=0, else 0. The master reads back byte N-1 during frame N.
- Undefined: no transmit register; miso tied to 0.

Test Plan:
- Single frame 0x2A, spi_clock period 16 clocks -> byte_valid pulse once; rd_data=0x2A, count=1 at the stated latency; rd_en -> empty=1, count=0.
- One slave_select window carrying 0x06,0x0F,0x01 -> three byte_valid pulses; pops return 0x06,0x0F,0x01 in order; frame_error=0.
- 17 frames 0x00..0x10 with no pops -> count=16, full=1, overflow=1; pops return 0x00..0x0F; 0x10 lost. clear_flags -> overflow=0.
- 5 bits of 0xFF then slave_select high, then full frame 0xC3 -> frame_error=1, FIFO holds only 0xC3.
- FIFO full; COMMIT cycle with rd_en=1 for 0x5A -> no overflow, count stays 16, 0x5A is the last entry popped.
- Assert reset after 4 bits of a frame -> all outputs at reset values immediately; next frame 0x81 received intact. With SPI_ECHO_EN: frames 0x12 then 0x34 -> miso shifts out 0x00 then 0x12.
